// File: rtl/tdc_multichannel_core.sv
// rtl/tdc_multichannel_core.sv - multi-channel coarse/fine TDC core with shared result FIFO
//
// One start pulse arms a run. A coarse counter then counts clk cycles until every
// channel has stopped or the counter saturates. Each stop captures a record of
// {timeout, ch_id, coarse, popcount(thermometer)}. Records are serialised into a
// first-word-fallthrough FIFO and drained over a valid/ready stream.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   start_i     single-cycle start pulse (ignored while a run is in progress)
//   stop_i      per-channel stop pulses
//   fine_i      per-channel thermometer snapshots, channel c at [c*FINE_TAPS +: FINE_TAPS]
//   ovf_clr_i   clears the sticky overflow flag
//   res_valid   FIFO not empty
//   res_ready   consumer accepts head record
//   res_data    head record {timeout, ch_id, coarse, fine}
//   busy        run in progress
//   ovf         sticky: a record was dropped
module tdc_multichannel_core #(
   parameter int NUM_CH     = 2,
   parameter int COARSE_W   = 12,
   parameter int FINE_TAPS  = 16,
   parameter int FIFO_DEPTH = 4,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int FINE_W    = $clog2(FINE_TAPS + 1),
   localparam int REC_W     = 1 + CH_W + COARSE_W + FINE_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start_i,
   input  logic [NUM_CH-1:0]           stop_i,
   input  logic [NUM_CH*FINE_TAPS-1:0] fine_i,
   input  logic                        ovf_clr_i,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [REC_W-1:0]            res_data,
   output logic                        busy,
   output logic                        ovf
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t               state_q, state_d;
   logic [COARSE_W-1:0]  coarse_q, coarse_d;
   logic [NUM_CH-1:0]    hit_q, hit_d;
   logic [NUM_CH-1:0]    pending_q, pending_d;
   logic [NUM_CH-1:0]    accept, clr_mask;
   logic [REC_W-1:0]     cap_q [NUM_CH];
   logic [REC_W-1:0]     cap_d [NUM_CH];
   logic                 ovf_q, ovf_d;
   logic                 drop, coarse_max;

   logic [REC_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]       count_q, count_d;
   logic                 full, pop, push_en;
   logic [REC_W-1:0]     push_data;

   // Bubble-tolerant fine code: count of ones, not position of the edge.
   function automatic logic [FINE_W-1:0] popcount(input logic [FINE_TAPS-1:0] v);
      logic [FINE_W-1:0] n;
      n = '0;
      for (int i = 0; i < FINE_TAPS; i++) begin
         n = n + FINE_W'(v[i]);
      end
      return n;
   endfunction

   assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign res_valid = (count_q != '0);
   assign pop       = res_valid && res_ready;
   assign res_data  = res_valid ? mem[rd_ptr_q] : '0;
   assign busy      = (state_q == S_RUN);
   assign ovf       = ovf_q;
   assign coarse_max = (coarse_q == {COARSE_W{1'b1}});

   always_comb begin
      state_d   = state_q;
      coarse_d  = coarse_q;
      hit_d     = hit_q;
      cap_d     = cap_q;
      accept    = '0;
      clr_mask  = '0;
      push_data = '0;
      drop      = 1'b0;

      // Lowest-index pending channel wins; scanning downwards leaves the lowest last.
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (pending_q[c]) begin
            push_data = cap_q[c];
            clr_mask  = '0;
            clr_mask[c] = 1'b1;
         end
      end
      // A full FIFO still takes a push when the head is popped on the same edge.
      push_en = (|pending_q) && (!full || pop);
      if (!push_en) begin
         clr_mask = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_RUN;
               coarse_d = '0;
               hit_d    = '0;
            end
         end
         S_RUN: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (!hit_q[c] && (stop_i[c] || coarse_max)) begin
                  hit_d[c] = 1'b1;
                  // A capture register being drained this very cycle is free again.
                  if (pending_q[c] && !clr_mask[c]) begin
                     drop = 1'b1;
                  end else begin
                     accept[c] = 1'b1;
                     if (stop_i[c]) begin
                        cap_d[c] = {1'b0, CH_W'(c), coarse_q,
                                    popcount(fine_i[c*FINE_TAPS +: FINE_TAPS])};
                     end else begin
                        cap_d[c] = {1'b1, CH_W'(c), {COARSE_W{1'b1}}, {FINE_W{1'b0}}};
                     end
                  end
               end
            end
            if ((&hit_d) || coarse_max) begin
               state_d = S_IDLE;
            end else begin
               coarse_d = coarse_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pending_d = (pending_q & ~clr_mask) | accept;
      // Set has priority over clear.
      ovf_d     = drop ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
      count_d   = count_q + (PTR_W+1)'(push_en) - (PTR_W+1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         coarse_q  <= '0;
         hit_q     <= '0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            cap_q[c] <= '0;
         end
      end else begin
         state_q   <= state_d;
         coarse_q  <= coarse_d;
         hit_q     <= hit_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         cap_q     <= cap_d;
         count_q   <= count_d;
         if (push_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: res_data is gated by res_valid.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

endmodule
